// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding imem request, 2-entry registered
// instruction buffer, redirect handling with discard of in-flight responses.
module fetch_unit #(
  parameter int unsigned    N        = 32,
  parameter logic [N-1:0]   RESET_PC = '0
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_redirect,
  input  logic [N-1:0]  i_redirect_pc,
  output logic          o_imem_req,
  output logic [N-1:0]  o_imem_addr,
  input  logic          i_imem_gnt,
  input  logic          i_imem_rvalid,
  input  logic [31:0]   i_imem_rdata,
  output logic          o_inst_valid,
  output logic [31:0]   o_inst,
  output logic [N-1:0]  o_inst_pc,
  input  logic          i_inst_ready,
  output logic          o_misaligned
);

  typedef enum logic [1:0] {
    ST_REQ,
    ST_WAIT,
    ST_DROP
  } state_t;

  state_t        state;
  logic [N-1:0]  fetch_pc;
  logic [N-1:0]  req_pc;
  logic [31:0]   buf_inst [2];
  logic [N-1:0]  buf_pc   [2];
  logic          rd_ptr;
  logic          wr_ptr;
  logic [1:0]    count;
  logic          misaligned_q;

  logic          req;
  logic          req_fire;
  logic          push;
  logic          pop;
  logic [N-1:0]  redirect_target;

  assign redirect_target = {i_redirect_pc[N-1:2], 2'b00};
  assign req      = (state == ST_REQ) && (count < 2'd2) && !i_rst;
  assign req_fire = req && i_imem_gnt;
  assign push     = (state == ST_WAIT) && i_imem_rvalid && !i_redirect;
  assign pop      = (count != 2'd0) && i_inst_ready && !i_redirect;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= ST_REQ;
      fetch_pc     <= RESET_PC;
      req_pc       <= '0;
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      count        <= '0;
      misaligned_q <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        buf_inst[i] <= '0;
        buf_pc[i]   <= '0;
      end
    end else begin
      misaligned_q <= i_redirect && (i_redirect_pc[1:0] != 2'b00);

      // Redirect flushes the buffer and overrides any same-cycle push or pop.
      if (i_redirect) begin
        fetch_pc <= redirect_target;
        rd_ptr   <= 1'b0;
        wr_ptr   <= 1'b0;
        count    <= '0;
      end else begin
        if (push) begin
          buf_inst[wr_ptr] <= i_imem_rdata;
          buf_pc[wr_ptr]   <= req_pc;
          wr_ptr           <= ~wr_ptr;
        end
        if (pop) begin
          rd_ptr <= ~rd_ptr;
        end
        count <= count + {1'b0, push} - {1'b0, pop};
        if (req_fire) begin
          req_pc   <= fetch_pc;
          fetch_pc <= fetch_pc + N'(4);
        end
      end

      unique case (state)
        ST_REQ: begin
          if (i_redirect) begin
            state <= req_fire ? ST_DROP : ST_REQ;
          end else if (req_fire) begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (i_redirect) begin
            state <= i_imem_rvalid ? ST_REQ : ST_DROP;
          end else if (i_imem_rvalid) begin
            state <= ST_REQ;
          end
        end
        ST_DROP: begin
          if (i_imem_rvalid) begin
            state <= ST_REQ;
          end
        end
        default: state <= ST_REQ;
      endcase
    end
  end

  assign o_imem_req   = req;
  assign o_imem_addr  = fetch_pc;
  assign o_inst_valid = (count != 2'd0) && !i_rst;
  assign o_inst       = i_rst ? '0 : buf_inst[rd_ptr];
  assign o_inst_pc    = i_rst ? '0 : buf_pc[rd_ptr];
  assign o_misaligned = misaligned_q && !i_rst;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: imem responder model, expected-instruction
// queue filled by directed stimulus, independent monitor popping on handshakes.
module tb_fetch_unit;

  localparam logic [31:0] DATA_KEY = 32'hC0DE_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic        clk;
  logic        i_rst;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic        o_inst_valid;
  logic [31:0] o_inst;
  logic [31:0] o_inst_pc;
  logic        i_inst_ready;
  logic        o_misaligned;

  int          n_checks = 0;
  int          n_pass   = 0;
  exp_t        exp_q[$];
  logic [31:0] gnt_log[$];
  int          gnt_budget = 0;
  int          rsp_lat    = 1;
  int          rsp_wait   = 0;
  bit          rsp_pending = 1'b0;
  logic [31:0] rsp_addr   = '0;

  fetch_unit #(.N(32), .RESET_PC(32'h0000_0000)) dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_gnt    (i_imem_gnt),
    .i_imem_rvalid (i_imem_rvalid),
    .i_imem_rdata  (i_imem_rdata),
    .o_inst_valid  (o_inst_valid),
    .o_inst        (o_inst),
    .o_inst_pc     (o_inst_pc),
    .i_inst_ready  (i_inst_ready),
    .o_misaligned  (o_misaligned)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, got, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_fetch(input logic [31:0] pc, input logic [31:0] inst);
    exp_t e;
    e.pc   = pc;
    e.inst = inst;
    exp_q.push_back(e);
  endtask

  // Instruction memory: grants while budget remains, answers rsp_lat cycles later.
  initial begin
    i_imem_gnt    = 1'b0;
    i_imem_rvalid = 1'b0;
    i_imem_rdata  = '0;
    forever begin
      @(negedge clk);
      #1;
      i_imem_rvalid = 1'b0;
      if (rsp_pending) begin
        if (rsp_wait == 0) begin
          i_imem_rvalid = 1'b1;
          i_imem_rdata  = rsp_addr ^ DATA_KEY;
          rsp_pending   = 1'b0;
        end else begin
          rsp_wait--;
        end
      end
      i_imem_gnt = (gnt_budget != 0);
      if (o_imem_req && i_imem_gnt) begin
        gnt_budget--;
        gnt_log.push_back(o_imem_addr);
        rsp_pending = 1'b1;
        rsp_addr    = o_imem_addr;
        rsp_wait    = rsp_lat - 1;
      end
    end
  end

  // Monitor: every instruction handed to decode must match the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!i_rst && !i_redirect && o_inst_valid && i_inst_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_inst: got pc=%h inst=%h required none", o_inst_pc, o_inst);
        end else begin
          e = exp_q.pop_front();
          chk("inst_pc", o_inst_pc, e.pc);
          chk("inst", o_inst, e.inst);
        end
      end
    end
  end

  initial begin
    i_rst         = 1'b1;
    i_redirect    = 1'b0;
    i_redirect_pc = '0;
    i_inst_ready  = 1'b0;

    // Reset state
    cycles(3); #2;
    chk("rst_req", 32'(o_imem_req), 32'd0);
    chk("rst_valid", 32'(o_inst_valid), 32'd0);
    chk("rst_misaligned", 32'(o_misaligned), 32'd0);
    chk("rst_inst", o_inst, 32'd0);
    chk("rst_inst_pc", o_inst_pc, 32'd0);

    // Sequential fetch 0x0, 0x4, 0x8 then ungranted request holds 0xC
    cycles(1);
    i_rst = 1'b0; i_inst_ready = 1'b1; gnt_budget = 3;
    expect_fetch(32'h0, 32'hC0DE_0000);
    expect_fetch(32'h4, 32'hC0DE_0004);
    expect_fetch(32'h8, 32'hC0DE_0008);
    cycles(8); #2;
    chk("seq_req_hold", 32'(o_imem_req), 32'd1);
    chk("seq_addr_hold", o_imem_addr, 32'hC);
    cycles(2); #2;
    chk("seq_addr_stable", o_imem_addr, 32'hC);
    chk("seq_grants", 32'(gnt_log.size()), 32'd3);
    chk("seq_gnt2", gnt_log[$], 32'h8);

    // Backpressure: two buffered, request drops, then drain and resume at 0x8
    cycles(1);
    i_rst = 1'b1; i_inst_ready = 1'b0;
    cycles(2);
    i_rst = 1'b0; gnt_budget = 3;
    expect_fetch(32'h0, 32'hC0DE_0000);
    expect_fetch(32'h4, 32'hC0DE_0004);
    expect_fetch(32'h8, 32'hC0DE_0008);
    cycles(6); #2;
    chk("full_req", 32'(o_imem_req), 32'd0);
    chk("full_valid", 32'(o_inst_valid), 32'd1);
    chk("full_head_pc", o_inst_pc, 32'h0);
    chk("full_grants", 32'(gnt_log.size()), 32'd5);
    cycles(1);
    i_inst_ready = 1'b1;
    cycles(6); #2;
    chk("resume_grants", 32'(gnt_log.size()), 32'd6);
    chk("resume_addr", gnt_log[$], 32'h8);

    // Redirect in WAIT without rvalid: response for 0xC dropped, next is 0x100
    cycles(1);
    gnt_budget = 1; rsp_lat = 3;
    cycles(1);
    i_redirect = 1'b1; i_redirect_pc = 32'h100;
    cycles(1);
    i_redirect = 1'b0; gnt_budget = 1; rsp_lat = 1;
    expect_fetch(32'h100, 32'hC0DE_0100);
    #2;
    chk("drop_misaligned", 32'(o_misaligned), 32'd0);
    cycles(1); #2;
    chk("drop_req", 32'(o_imem_req), 32'd0);
    cycles(1); #2;
    chk("drop_next_req", 32'(o_imem_req), 32'd1);
    chk("drop_next_addr", o_imem_addr, 32'h100);
    cycles(4);

    // Misaligned redirect to 0x202 and redirect latency
    i_redirect = 1'b1; i_redirect_pc = 32'h202;
    expect_fetch(32'h200, 32'hC0DE_0200);
    cycles(1);
    i_redirect = 1'b0; gnt_budget = 1;
    #2;
    chk("mis_pulse", 32'(o_misaligned), 32'd1);
    chk("mis_req", 32'(o_imem_req), 32'd1);
    chk("mis_addr", o_imem_addr, 32'h200);
    cycles(1); #2;
    chk("mis_pulse_end", 32'(o_misaligned), 32'd0);
    chk("lat_valid_t2", 32'(o_inst_valid), 32'd0);
    cycles(1); #2;
    chk("lat_valid_t3", 32'(o_inst_valid), 32'd1);
    cycles(2);

    // Redirect in REQ coinciding with a grant: granted 0x204 is discarded
    i_redirect = 1'b1; i_redirect_pc = 32'h300; gnt_budget = 1;
    expect_fetch(32'h300, 32'hC0DE_0300);
    cycles(1);
    i_redirect = 1'b0; gnt_budget = 1;
    #2;
    chk("gnt_redir_req", 32'(o_imem_req), 32'd0);
    cycles(1); #2;
    chk("gnt_redir_addr", o_imem_addr, 32'h300);
    cycles(4);

    // Back-to-back redirects: the later one wins
    i_redirect = 1'b1; i_redirect_pc = 32'h400;
    cycles(1);
    i_redirect_pc = 32'h500;
    cycles(1);
    i_redirect = 1'b0; gnt_budget = 1;
    expect_fetch(32'h500, 32'hC0DE_0500);
    #2;
    chk("b2b_addr", o_imem_addr, 32'h500);
    cycles(4);

    // PC wrap from 0xFFFF_FFFC
    i_redirect = 1'b1; i_redirect_pc = 32'hFFFF_FFFC;
    cycles(1);
    i_redirect = 1'b0; gnt_budget = 2;
    expect_fetch(32'hFFFF_FFFC, 32'h3F21_FFFC);
    expect_fetch(32'h0000_0000, 32'hC0DE_0000);
    cycles(6); #2;
    chk("wrap_gnt", gnt_log[$], 32'h0);
    chk("wrap_next_addr", o_imem_addr, 32'h4);

    // Reset with one buffered and one outstanding; stale response after release
    cycles(1);
    i_redirect = 1'b1; i_redirect_pc = 32'h40; i_inst_ready = 1'b0;
    cycles(1);
    i_redirect = 1'b0; gnt_budget = 2; rsp_lat = 2;
    expect_fetch(32'h40, 32'hC0DE_0040);
    cycles(3); #2;
    chk("pre_rst_valid", 32'(o_inst_valid), 32'd1);
    chk("pre_rst_addr", o_imem_addr, 32'h44);
    cycles(1);
    i_rst = 1'b1;
    exp_q.delete();
    #2;
    chk("mid_rst_req", 32'(o_imem_req), 32'd0);
    chk("mid_rst_valid", 32'(o_inst_valid), 32'd0);
    chk("mid_rst_inst", o_inst, 32'd0);
    cycles(1);
    i_rst = 1'b0; gnt_budget = 1; rsp_lat = 1; i_inst_ready = 1'b1;
    expect_fetch(32'h0, 32'hC0DE_0000);
    #2;
    chk("post_rst_req", 32'(o_imem_req), 32'd1);
    chk("post_rst_addr", o_imem_addr, 32'h0);
    cycles(4); #2;
    chk("post_rst_gnt", gnt_log[$], 32'h0);
    cycles(2); #2;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
